// File: rtl/c64_bus_ctrl.sv
// C64 memory-side bus controller: paces the 6502 core with cpu_ce, decodes
// bank-switched targets, runs the external req/ack handshake and hosts the 6510 I/O port.
module c64_bus_ctrl #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] cpu_ab,
  input  logic [7:0]  cpu_do,
  input  logic        cpu_we,
  output logic [7:0]  cpu_di,
  output logic        cpu_ce,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic [2:0]  mem_sel,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  input  logic [5:0]  port_in,
  output logic [5:0]  port_out,
  output logic [5:0]  port_dir,
  output logic        bus_err
);
  typedef enum logic [1:0] {S_ISSUE, S_WAIT, S_DONE} state_t;

  localparam logic [2:0] SEL_RAM = 3'd0, SEL_BASIC = 3'd1, SEL_KERNAL = 3'd2,
                         SEL_CHAR = 3'd3, SEL_IO = 3'd4;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [5:0]  ddr_q, ddr_d, data_q, data_d;
  logic [7:0]  di_q, di_d, wdata_q, wdata_d;
  logic [15:0] addr_q, addr_d;
  logic [2:0]  sel_q, sel_d;
  logic        req_q, req_d, we_q, we_d, err_q, err_d;

  logic [5:0] eff;
  logic       loram, hiram, charen, is_port;
  logic [2:0] rd_sel, new_sel;
  logic [7:0] port_rd;

  // Bank bits come from the port state before any write in this ISSUE cycle.
  assign eff     = (data_q & ddr_q) | (port_in & ~ddr_q);
  assign loram   = eff[0];
  assign hiram   = eff[1];
  assign charen  = eff[2];
  assign is_port = (cpu_ab[15:1] == 15'd0);
  assign port_rd = cpu_ab[0] ? {2'b00, eff} : {2'b00, ddr_q};

  always_comb begin
    rd_sel = SEL_RAM;
    if (cpu_ab[15:13] == 3'b101)
      rd_sel = (loram && hiram) ? SEL_BASIC : SEL_RAM;
    else if (cpu_ab[15:12] == 4'hD)
      rd_sel = (!loram && !hiram) ? SEL_RAM : (charen ? SEL_IO : SEL_CHAR);
    else if (cpu_ab[15:13] == 3'b111)
      rd_sel = hiram ? SEL_KERNAL : SEL_RAM;
  end

  assign new_sel = (cpu_we && rd_sel != SEL_IO) ? SEL_RAM : rd_sel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ddr_d   = ddr_q;
    data_d  = data_q;
    di_d    = di_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    sel_d   = sel_q;
    req_d   = req_q;
    err_d   = err_q;
    unique case (state_q)
      S_ISSUE: begin
        addr_d  = cpu_ab;
        wdata_d = cpu_do;
        we_d    = cpu_we;
        sel_d   = new_sel;
        cnt_d   = 8'd0;
        if (is_port) begin
          state_d = S_DONE;
          if (cpu_we) begin
            if (cpu_ab[0]) data_d = cpu_do[5:0];
            else           ddr_d  = cpu_do[5:0];
          end else begin
            di_d = port_rd;
          end
        end else begin
          req_d   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // An ack in the final WAIT cycle takes priority over the timeout.
        if (mem_ack) begin
          req_d   = 1'b0;
          state_d = S_DONE;
          if (!we_q) di_d = mem_rdata;
        end else if (cnt_q == CNT_LAST) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_DONE;
          if (!we_q) di_d = 8'hFF;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE:  state_d = S_ISSUE;
      default: state_d = S_ISSUE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_ISSUE;
      cnt_q   <= 8'd0;
      ddr_q   <= 6'd0;
      data_q  <= 6'd0;
      di_q    <= 8'h00;
      addr_q  <= 16'd0;
      wdata_q <= 8'd0;
      we_q    <= 1'b0;
      sel_q   <= SEL_RAM;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ddr_q   <= ddr_d;
      data_q  <= data_d;
      di_q    <= di_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      req_q   <= req_d;
      err_q   <= err_d;
    end
  end

  assign cpu_ce    = (state_q == S_DONE);
  assign cpu_di    = di_q;
  assign mem_req   = req_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_sel   = sel_q;
  assign port_out  = data_q;
  assign port_dir  = ddr_q;
  assign bus_err   = err_q;
endmodule

// File: tb/tb_c64_bus_ctrl.sv
// Directed bench for c64_bus_ctrl: decode, I/O port, handshake timing, timeout, reset.
module tb_c64_bus_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cpu_ab = 16'h0000;
  logic [7:0]  cpu_do = 8'h00;
  logic        cpu_we = 1'b0;
  logic [7:0]  cpu_di;
  logic        cpu_ce, mem_req, mem_we, mem_ack = 1'b0, bus_err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata = 8'h00;
  logic [2:0]  mem_sel;
  logic [5:0]  port_in = 6'h3F, port_out, port_dir;

  int n_chk = 0;
  int n_fail = 0;

  c64_bus_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we),
    .cpu_di(cpu_di), .cpu_ce(cpu_ce), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_sel(mem_sel), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .port_in(port_in), .port_out(port_out),
    .port_dir(port_dir), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  // Entered at a negedge with the FSM in ISSUE; returns at the negedge of the next ISSUE.
  // ack_k = WAIT cycle in which mem_ack is given (0 = never).
  task automatic do_access(input logic [15:0] a, input logic we, input logic [7:0] wd,
                           input int ack_k, input logic [7:0] rd,
                           output int ce_cyc, output int req_cyc, output int ce_cnt);
    int cyc = 0;
    int wc = 0;
    ce_cyc = 0; req_cyc = 0; ce_cnt = 0;
    cpu_ab = a; cpu_we = we; cpu_do = wd; mem_rdata = rd;
    while (ce_cnt == 0 && cyc < 40) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (mem_req) begin
        wc++; req_cyc++;
        mem_ack = (wc == ack_k);
      end else mem_ack = 1'b0;
      if (cpu_ce) begin ce_cnt++; ce_cyc = cyc; end
    end
    mem_ack = 1'b0;
    n_chk++;
    if (ce_cnt == 0) begin
      n_fail++;
      $display("FAIL access_timeout addr=%h: no cpu_ce within 40 cycles", a);
    end
    @(posedge clk); @(negedge clk);
    if (cpu_ce) ce_cnt++;
  endtask

  task automatic test_reset();
    n_chk++;
    if ({cpu_di, cpu_ce, mem_req, mem_addr, mem_wdata, mem_we, mem_sel, port_out, port_dir, bus_err} !== 56'd0) begin
      n_fail++;
      $display("FAIL reset_values got di=%h ce=%b req=%b addr=%h wd=%h we=%b sel=%0d po=%h pd=%h err=%b expected all zero",
               cpu_di, cpu_ce, mem_req, mem_addr, mem_wdata, mem_we, mem_sel, port_out, port_dir, bus_err);
    end
    @(negedge clk); reset = 1'b0;
  endtask

  task automatic test_kernal_read();
    int ce_cyc, req_cyc, ce_cnt;
    do_access(16'hE000, 1'b0, 8'h00, 2, 8'h4C, ce_cyc, req_cyc, ce_cnt);
    n_chk++;
    if (mem_sel !== 3'd2 || mem_addr !== 16'hE000 || cpu_di !== 8'h4C) begin
      n_fail++;
      $display("FAIL kernal_read sel=%0d addr=%h di=%h expected 2 E000 4C", mem_sel, mem_addr, cpu_di);
    end
    n_chk++;
    if (ce_cyc !== 3 || ce_cnt !== 1 || req_cyc !== 2) begin
      n_fail++;
      $display("FAIL kernal_timing ce_cyc=%0d ce_cnt=%0d req=%0d expected 3 1 2", ce_cyc, ce_cnt, req_cyc);
    end
  endtask

  task automatic test_port();
    int ce_cyc, req_cyc, ce_cnt;
    do_access(16'h0000, 1'b1, 8'h07, 0, 8'h00, ce_cyc, req_cyc, ce_cnt);
    do_access(16'h0001, 1'b1, 8'h05, 0, 8'h00, ce_cyc, req_cyc, ce_cnt);
    n_chk++;
    if (port_dir !== 6'h07 || port_out !== 6'h05 || req_cyc !== 0 || ce_cyc !== 1) begin
      n_fail++;
      $display("FAIL port_write dir=%h out=%h req=%0d ce_cyc=%0d expected 07 05 0 1", port_dir, port_out, req_cyc, ce_cyc);
    end
    do_access(16'h0001, 1'b0, 8'h00, 0, 8'h00, ce_cyc, req_cyc, ce_cnt);
    n_chk++;
    if (cpu_di !== 8'h3D) begin
      n_fail++; $display("FAIL port_read_data got %h expected 3d", cpu_di);
    end
    do_access(16'h0000, 1'b0, 8'h00, 0, 8'h00, ce_cyc, req_cyc, ce_cnt);
    n_chk++;
    if (cpu_di !== 8'h07) begin
      n_fail++; $display("FAIL port_read_ddr got %h expected 07", cpu_di);
    end
    do_access(16'hA000, 1'b0, 8'h00, 1, 8'h12, ce_cyc, req_cyc, ce_cnt);
    n_chk++;
    if (mem_sel !== 3'd0 || cpu_di !== 8'h12) begin
      n_fail++; $display("FAIL basic_off sel=%0d di=%h expected 0 12", mem_sel, cpu_di);
    end
    do_access(16'hD000, 1'b0, 8'h00, 1, 8'h34, ce_cyc, req_cyc, ce_cnt);
    n_chk++;
    if (mem_sel !== 3'd4) begin
      n_fail++; $display("FAIL io_map sel=%0d expected 4", mem_sel);
    end
  endtask

  task automatic test_write_under_rom();
    int ce_cyc, req_cyc, ce_cnt;
    do_access(16'h0001, 1'b1, 8'h07, 0, 8'h00, ce_cyc, req_cyc, ce_cnt);
    do_access(16'hA123, 1'b0, 8'h00, 1, 8'h99, ce_cyc, req_cyc, ce_cnt);
    n_chk++;
    if (mem_sel !== 3'd1 || cpu_di !== 8'h99) begin
      n_fail++; $display("FAIL basic_on sel=%0d di=%h expected 1 99", mem_sel, cpu_di);
    end
    do_access(16'hE000, 1'b1, 8'hAA, 3, 8'h55, ce_cyc, req_cyc, ce_cnt);
    n_chk++;
    if (mem_sel !== 3'd0 || mem_we !== 1'b1 || mem_wdata !== 8'hAA || req_cyc !== 3) begin
      n_fail++;
      $display("FAIL write_kernal sel=%0d we=%b wd=%h req=%0d expected 0 1 aa 3", mem_sel, mem_we, mem_wdata, req_cyc);
    end
    n_chk++;
    if (cpu_di !== 8'h99) begin
      n_fail++; $display("FAIL write_keeps_di got %h expected 99", cpu_di);
    end
    do_access(16'h0001, 1'b1, 8'h03, 0, 8'h00, ce_cyc, req_cyc, ce_cnt);
    do_access(16'hD000, 1'b0, 8'h00, 1, 8'h77, ce_cyc, req_cyc, ce_cnt);
    n_chk++;
    if (mem_sel !== 3'd3) begin
      n_fail++; $display("FAIL char_map sel=%0d expected 3", mem_sel);
    end
    do_access(16'hD020, 1'b1, 8'h0E, 1, 8'h00, ce_cyc, req_cyc, ce_cnt);
    n_chk++;
    if (mem_sel !== 3'd0) begin
      n_fail++; $display("FAIL write_under_char sel=%0d expected 0", mem_sel);
    end
  endtask

  task automatic test_ack_last();
    int ce_cyc, req_cyc, ce_cnt;
    do_access(16'h4000, 1'b0, 8'h00, 16, 8'h5A, ce_cyc, req_cyc, ce_cnt);
    n_chk++;
    if (cpu_di !== 8'h5A || bus_err !== 1'b0 || req_cyc !== 16 || ce_cyc !== 17) begin
      n_fail++;
      $display("FAIL ack_last di=%h err=%b req=%0d ce_cyc=%0d expected 5a 0 16 17", cpu_di, bus_err, req_cyc, ce_cyc);
    end
  endtask

  task automatic test_timeout();
    int ce_cyc, req_cyc, ce_cnt;
    do_access(16'h1234, 1'b0, 8'h00, 0, 8'h00, ce_cyc, req_cyc, ce_cnt);
    n_chk++;
    if (cpu_di !== 8'hFF || bus_err !== 1'b1 || req_cyc !== 16 || ce_cyc !== 17 || mem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout di=%h err=%b req=%0d ce_cyc=%0d expected ff 1 16 17", cpu_di, bus_err, req_cyc, ce_cyc);
    end
    do_access(16'h2000, 1'b0, 8'h00, 1, 8'h11, ce_cyc, req_cyc, ce_cnt);
    n_chk++;
    if (cpu_di !== 8'h11 || bus_err !== 1'b1 || ce_cyc !== 2) begin
      n_fail++;
      $display("FAIL after_timeout di=%h err=%b ce_cyc=%0d expected 11 1 2", cpu_di, bus_err, ce_cyc);
    end
  endtask

  task automatic test_reset_mid_wait();
    int ce_cyc, req_cyc, ce_cnt;
    int ce_seen = 0;
    cpu_ab = 16'h1234; cpu_we = 1'b0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      if (cpu_ce) ce_seen++;
    end
    n_chk++;
    if (mem_req !== 1'b1) begin
      n_fail++; $display("FAIL wait3_req got %b expected 1", mem_req);
    end
    #1 reset = 1'b1;
    #1;
    n_chk++;
    if (mem_req !== 1'b0 || bus_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_async req=%b err=%b expected 0 0", mem_req, bus_err);
    end
    @(posedge clk); @(negedge clk);
    if (cpu_ce) ce_seen++;
    cpu_ab = 16'hE100;
    reset = 1'b0;
    n_chk++;
    if (port_dir !== 6'h00 || ce_seen !== 0) begin
      n_fail++; $display("FAIL reset_port dir=%h ce_seen=%0d expected 00 0", port_dir, ce_seen);
    end
    do_access(16'hE100, 1'b0, 8'h00, 1, 8'h20, ce_cyc, req_cyc, ce_cnt);
    n_chk++;
    if (mem_addr !== 16'hE100 || mem_sel !== 3'd2 || cpu_di !== 8'h20 || ce_cyc !== 2) begin
      n_fail++;
      $display("FAIL post_reset addr=%h sel=%0d di=%h ce_cyc=%0d expected e100 2 20 2", mem_addr, mem_sel, cpu_di, ce_cyc);
    end
  endtask

  initial begin
    #12;
    test_reset();
    test_kernal_read();
    test_port();
    test_write_under_rom();
    test_ack_last();
    test_timeout();
    test_reset_mid_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
